// File: rtl/core_ctrl_pkg.sv
// Shared control types for the pipeline hazard scheduler.
// Holds the FSM encoding, the x0 register index and the stage-control bundle.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic pc_redirect;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
    logic halted;
  } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline with halt drain FSM.
// Controls are combinational; only FSM, drain count and perf counters are registered.
module hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_halt_req,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect_taken,
  input  logic             dmem_busy,
  input  logic             resume,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_t   state;
  ctrl_state_t   state_nx;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nx;
  stage_ctrl_t   ctrl;
  logic          lu;

  assign lu = ex_mem_read && (ex_rd != REG_X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == DRAIN)) begin
      assert (!ex_redirect_taken);
    end
  end

  always_comb begin
    ctrl     = '0;
    state_nx = state;
    dcnt_nx  = dcnt;
    if (!rst) begin
      unique case (state)
        RUN: begin
          // EX is frozen while memory waits, so a redirect stays pending
          if (dmem_busy) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.pipe_freeze = 1'b1;
          end else if (ex_redirect_taken) begin
            ctrl.pc_redirect = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (lu) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (id_halt_req) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
            state_nx         = DRAIN;
            dcnt_nx          = DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_flush = 1'b1;
          ctrl.pipe_freeze = dmem_busy;
          if (!dmem_busy) begin
            if (dcnt == '0) begin
              state_nx = HALTED;
            end else begin
              dcnt_nx = dcnt - DW'(1);
            end
          end
        end
        HALTED: begin
          ctrl.halted      = 1'b1;
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_stall = 1'b1;
          if (resume) begin
            state_nx = RUN;
          end
        end
        default: begin
          state_nx = RUN;
        end
      endcase
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign pc_redirect = ctrl.pc_redirect;
  assign if_id_stall = ctrl.if_id_stall;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign pipe_freeze = ctrl.pipe_freeze;
  assign halted      = ctrl.halted;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.pc_stall && (state != HALTED)),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.if_id_flush),
    .q   (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It sits beside the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, data-memory wait and EX-stage redirects, and issues per-stage stall/flush/freeze controls.
- Gates the redirect into the PC register.
- Sequences a halt drain (ECALL/EBREAK) with a small FSM.
- Keeps saturating stall and flush performance counters.

Parameters:
DRAIN_CYCLES, 3, cycles held in DRAIN after halt acceptance (halt instr ID->WB)
CNT_W, 16, width of perf counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  rs1 of instr in ID
id_rs2  in  5  rs2 of instr in ID
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
id_halt_req  in  1  ID instr is ECALL/EBREAK
ex_rd  in  5  rd of instr in EX
ex_mem_read  in  1  EX instr is a load
ex_redirect_taken  in  1  EX resolved taken branch/jump
dmem_busy  in  1  data memory not ready this cycle
resume  in  1  leave HALTED
pc_stall  out  1  hold PC
pc_redirect  out  1  redirect enable to PC register
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_flush  out  1  bubble ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with pc_stall=1 (excl. HALTED)
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
Reset and timing:
- rst=1 takes priority over everything. State<=RUN, drain counter<=0, stall_cnt<=0, flush_cnt<=0.
- While rst=1, all 1-bit outputs read 0.
- All control outputs are combinational from current state and inputs, with zero latency. Only the FSM, drain counter and perf counters are registered.

Load-use hazard:
- lu = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).

FSM states: RUN, DRAIN, HALTED.

RUN, evaluated in priority order:
1. dmem_busy: pc_stall=1, if_id_stall=1, pipe_freeze=1, pc_redirect=0, no flushes. The EX redirect stays pending because EX is frozen.
2. ex_redirect_taken: pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_stall=0. A lu or id_halt_req in the same cycle is ignored (wrong path).
3. lu: pc_stall=1, if_id_stall=1, id_ex_flush=1. This gives exactly one bubble; the next cycle lu is false because the load has moved to MEM.
4. id_halt_req: pc_stall=1, if_id_flush=1. Go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
5. Otherwise all outputs are 0.

DRAIN:
- pc_stall=1 and if_id_flush=1 on every cycle.
- dmem_busy additionally asserts pipe_freeze and holds the counter.
- ex_redirect_taken is ignored and pc_redirect=0. (Assertion: it must not occur in DRAIN.)
- When the counter is 0, go to HALTED; otherwise decrement.

HALTED:
- halted=1, pc_stall=1, if_id_stall=1, all flushes 0.
- resume=1 returns to RUN next cycle; halted drops in that cycle.
- resume in any other state is ignored.

Counters:
- stall_cnt increments when pc_stall=1 and state!=HALTED.
- flush_cnt increments when if_id_flush=1.
- Both saturate at all-ones and do not wrap.

Reset mid-DRAIN or in HALTED: return to RUN immediately, with no residual flush.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state enum {RUN, DRAIN, HALTED}, 2 bits;
  - REG_X0 constant;
  - the bundle of stage-control signal names.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output q, saturating), instantiated twice. The FSM stays in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt 0->1. With ex_rd=0 instead -> no stall.
- Redirect plus lu in the same cycle -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt +1.
- dmem_busy for 4 cycles with ex_redirect_taken=1 -> pc_redirect=0 and pipe_freeze=1 for all 4 cycles; pc_redirect=1 in cycle 5.
- id_halt_req=1 with DRAIN_CYCLES=3 -> DRAIN for 3 cycles, halted=1 on cycle 5 after the request cycle; resume=1 -> halted=0 next cycle, pc_stall=0.
- Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15.
- rst asserted in DRAIN -> next cycle state RUN, all outputs 0, counters 0.
